// File: rtl/regfile_2w2r_clr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2w2r_clr
// Purpose  : DEPTH x DATA_W register file, 2 write / 2 combinational read ports,
//            optional bypass and zero register, plus a sequential bulk-clear engine.
// Revision : 1.0  initial parametrised release
// ============================================================================
module regfile_2w2r_clr #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_W-1:0]     SA,
    input  logic [ADDR_W-1:0]     SB,
    output logic [DATA_W-1:0]     DataA,
    output logic [DATA_W-1:0]     DataB,
    input  logic                  LD0,
    input  logic [ADDR_W-1:0]     DR0,
    input  logic [DATA_W-1:0]     D_in0,
    input  logic                  LD1,
    input  logic [ADDR_W-1:0]     DR1,
    input  logic [DATA_W-1:0]     D_in1,
    input  logic                  CLR_REQ,
    output logic                  CLR_BUSY,
    output logic                  CLR_DONE,
    output logic [2**ADDR_W-1:0]  DIRTY
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_W-1:0]      ptr;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]       dirty;
    logic                   busy;
    logic                   wr0_ok;
    logic                   wr1_ok;

    assign busy = (state == CLEAR);

    // A write is accepted only outside the clear sweep and never to a hard-wired zero entry.
    assign wr0_ok = LD0 && !busy && !((ZERO_R0 != 0) && (DR0 == '0));
    assign wr1_ok = LD1 && !busy && !((ZERO_R0 != 0) && (DR1 == '0));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        CLR_BUSY   = 1'b0;
        CLR_DONE   = 1'b0;
        case (state)
            IDLE: begin
                if (CLR_REQ) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                CLR_BUSY = 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                CLR_DONE   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pointer idles at zero so the sweep always starts from entry 0.
    always_ff @(posedge CLK) begin
        if (RESET || !busy) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + 1'b1;
        end
    end

    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dirty <= '0;
        end else if (busy) begin
            mem[ptr]   <= '0;
            dirty[ptr] <= 1'b0;
        end else begin
            if (wr0_ok) begin
                mem[DR0]   <= D_in0;
                dirty[DR0] <= 1'b1;
            end
            if (wr1_ok) begin
                mem[DR1]   <= D_in1;
                dirty[DR1] <= 1'b1;
            end
        end
    end

    assign DIRTY = dirty;

    always_comb begin
        DataA = mem[SA];
        if ((BYPASS != 0) && wr1_ok && (DR1 == SA)) begin
            DataA = D_in1;
        end else if ((BYPASS != 0) && wr0_ok && (DR0 == SA)) begin
            DataA = D_in0;
        end
        if ((ZERO_R0 != 0) && (SA == '0)) begin
            DataA = '0;
        end
    end

    always_comb begin
        DataB = mem[SB];
        if ((BYPASS != 0) && wr1_ok && (DR1 == SB)) begin
            DataB = D_in1;
        end else if ((BYPASS != 0) && wr0_ok && (DR0 == SB)) begin
            DataB = D_in0;
        end
        if ((ZERO_R0 != 0) && (SB == '0)) begin
            DataB = '0;
        end
    end

endmodule
`default_nettype wire
